// File: rtl/conv_pkg.sv
// Shared constants for the converter display path: segment table, blank pattern
// and digit-count width.
package conv_pkg;

    localparam int DIG_CNT_W = 3;

    typedef logic [3:0] code_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}, indexed by hex code 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex-code to active-low 7-segment decoder.
module seg7_dec
    import conv_pkg::*;
(
    input  code_t      code,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[code];

endmodule

// File: rtl/conv_seg_scan.sv
// Four-digit common-anode scanner for converter codes: shift buffer, prescaled
// digit scan, registered outputs. Build option: CONV_SEG_LZ_BLANK_EN (leading-zero blanking).
module conv_seg_scan
    import conv_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           code_i,
    input  logic                 code_valid,
    input  logic                 clear,
    output logic [6:0]           seg_n,
    output logic [3:0]           an_n,
    output logic [DIG_CNT_W-1:0] dig_cnt
);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    code_t                dig_buf_q [4];
    code_t                dig_buf_d [4];
    logic [DIG_CNT_W-1:0] dig_cnt_d;
    logic                 tick;
    logic                 show;
    logic                 lz_blank;
    logic [6:0]           dec_seg;
    logic [6:0]           seg_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        tick      = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        sel_d     = tick ? sel_q + 2'd1 : sel_q;
        dig_buf_d = dig_buf_q;
        dig_cnt_d = dig_cnt;
        if (clear) begin
            for (int i = 0; i < 4; i++) dig_buf_d[i] = '0;
            dig_cnt_d = '0;
        end else if (code_valid) begin
            dig_buf_d[3] = dig_buf_q[2];
            dig_buf_d[2] = dig_buf_q[1];
            dig_buf_d[1] = dig_buf_q[0];
            dig_buf_d[0] = code_i;
            if (dig_cnt != DIG_CNT_W'(4)) dig_cnt_d = dig_cnt + 1'b1;
        end
    end

    // Outputs are built from next-state values so the displayed digit moves on
    // the same edge as the select, giving exactly SCAN_DIV cycles per digit.
    seg7_dec u_dec (
        .code  (dig_buf_d[sel_d]),
        .seg_n (dec_seg)
    );

`ifdef CONV_SEG_LZ_BLANK_EN
    always_comb begin
        lz_blank = (sel_d != 2'd0);
        for (int j = 1; j < 4; j++) begin
            if (j >= int'(sel_d) && j < int'(dig_cnt_d) && dig_buf_d[j] != '0)
                lz_blank = 1'b0;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        show  = ({1'b0, sel_d} < dig_cnt_d);
        seg_d = (show && !lz_blank) ? dec_seg : SEG_BLANK;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the small digit buffer is reset along with the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            dig_cnt <= '0;
            for (int i = 0; i < 4; i++) dig_buf_q[i] <= '0;
            an_n    <= 4'b1110;
            seg_n   <= SEG_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            dig_cnt   <= dig_cnt_d;
            dig_buf_q <= dig_buf_d;
            an_n      <= ~(4'b0001 << sel_d);
            seg_n     <= seg_d;
        end
    end

endmodule

// File: tb/tb_conv_seg_scan.sv
// Self-checking bench for conv_seg_scan (SCAN_DIV=4): scenario tasks plus a
// randomized run, compared against a queue-based display model.
module tb_conv_seg_scan;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code_i = '0;
    logic       code_valid = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic [2:0] dig_cnt;

    int checks   = 0;
    int failures = 0;

    conv_seg_scan #(.SCAN_DIV(SCAN_DIV), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_i     (code_i),
        .code_valid (code_valid),
        .clear      (clear),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .dig_cnt    (dig_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset and the loaded codes, newest first.
    int         edges = 0;
    logic [3:0] codes[$];

    logic [6:0] hex_map [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int exp_digit();
        return (edges / SCAN_DIV) % 4;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        a = 4'b1111;
        a[exp_digit()] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_seg();
        int  d;
        bit  all_zero;
        d = exp_digit();
        if (d >= codes.size()) return 7'h7F;
`ifdef CONV_SEG_LZ_BLANK_EN
        all_zero = (d != 0);
        for (int j = d; j < codes.size(); j++)
            if (codes[j] != 4'h0) all_zero = 0;
        if (all_zero) return 7'h7F;
`else
        all_zero = 0;
`endif
        return hex_map[codes[d]];
    endfunction

    task automatic cycle(input logic r, input logic v, input logic c, input logic [3:0] code);
        rst = r; code_valid = v; clear = c; code_i = code;
        @(posedge clk);
        if (r) begin
            edges = 0;
            codes.delete();
        end else begin
            edges++;
            if (c) codes.delete();
            else if (v) begin
                codes.push_front(code);
                if (codes.size() > 4) void'(codes.pop_back());
            end
        end
        #1;
        rst = 1'b0; code_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 4'h0);
        cycle(1, 1, 0, 4'h9);
        checks++;
        if (an_n !== 4'b1110 || seg_n !== 7'h7F || dig_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: an_n=%b seg_n=%h dig_cnt=%0d, want 1110 7f 0", an_n, seg_n, dig_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 4'h0);
            checks++;
            if (an_n !== exp_an() || seg_n !== 7'h7F || dig_cnt !== 3'd0) begin
                failures++;
                $display("FAIL idle_scan[%0d]: an_n=%b seg_n=%h dig_cnt=%0d, want %b 7f 0", i, an_n, seg_n, dig_cnt, exp_an());
            end
        end
    endtask

    task automatic test_single_capture();
        cycle(0, 1, 0, 4'h3);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (an_n !== exp_an() || seg_n !== ((exp_digit() == 0) ? 7'h30 : 7'h7F) || dig_cnt !== 3'd1) begin
                failures++;
                $display("FAIL single_capture[%0d]: an_n=%b seg_n=%h dig_cnt=%0d, want %b %h 1", i, an_n, seg_n, dig_cnt, exp_an(), exp_seg());
            end
            cycle(0, 0, 0, 4'h0);
        end
    endtask

    task automatic test_shift_saturate();
        logic [6:0] want [4] = '{7'h00, 7'h0E, 7'h08, 7'h24};
        logic [3:0] seq  [5] = '{4'h1, 4'h2, 4'hA, 4'hF, 4'h8};
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, seq[i]);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (an_n !== exp_an() || seg_n !== want[exp_digit()] || dig_cnt !== 3'd4) begin
                failures++;
                $display("FAIL shift_saturate[%0d]: an_n=%b seg_n=%h dig_cnt=%0d, want %b %h 4", i, an_n, seg_n, dig_cnt, exp_an(), want[exp_digit()]);
            end
            cycle(0, 0, 0, 4'h0);
        end
    endtask

    task automatic test_clear_collision();
        cycle(0, 1, 1, 4'h5);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (an_n !== exp_an() || seg_n !== 7'h7F || dig_cnt !== 3'd0) begin
                failures++;
                $display("FAIL clear_collision[%0d]: an_n=%b seg_n=%h dig_cnt=%0d, want %b 7f 0", i, an_n, seg_n, dig_cnt, exp_an());
            end
            cycle(0, 0, 0, 4'h0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int waited;
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'($urandom_range(0, 15)));
        waited = 0;
        while (an_n !== 4'b1011 && waited < 40) begin
            cycle(0, 0, 0, 4'h0);
            waited++;
        end
        checks++;
        if (an_n !== 4'b1011 || dig_cnt !== 3'd3) begin
            failures++;
            $display("FAIL reset_mid_setup: an_n=%b dig_cnt=%0d after %0d cycles, want 1011 3", an_n, dig_cnt, waited);
        end
        cycle(1, 1, 0, 4'h6);
        checks++;
        if (an_n !== 4'b1110 || seg_n !== 7'h7F || dig_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_scan: an_n=%b seg_n=%h dig_cnt=%0d, want 1110 7f 0", an_n, seg_n, dig_cnt);
        end
    endtask

    task automatic test_leading_zero();
`ifdef CONV_SEG_LZ_BLANK_EN
        logic [6:0] want [4] = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
`else
        logic [6:0] want [4] = '{7'h78, 7'h40, 7'h40, 7'h7F};
`endif
        cycle(0, 1, 0, 4'h0);
        cycle(0, 1, 0, 4'h0);
        cycle(0, 1, 0, 4'h7);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (an_n !== exp_an() || seg_n !== want[exp_digit()] || dig_cnt !== 3'd3) begin
                failures++;
                $display("FAIL leading_zero[%0d]: an_n=%b seg_n=%h dig_cnt=%0d, want %b %h 3", i, an_n, seg_n, dig_cnt, exp_an(), want[exp_digit()]);
            end
            cycle(0, 0, 0, 4'h0);
        end
    endtask

    task automatic test_random();
        logic r, v, c;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 6);
            v = ($urandom_range(0, 99) < 35);
            cycle(r, v, c, 4'($urandom_range(0, 15)));
            checks++;
            if (an_n !== exp_an() || seg_n !== exp_seg() || dig_cnt !== 3'(codes.size())) begin
                failures++;
                $display("FAIL random[%0d]: an_n=%b seg_n=%h dig_cnt=%0d, want %b %h %0d", i, an_n, seg_n, dig_cnt, exp_an(), exp_seg(), codes.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_shift_saturate();
        test_clear_collision();
        test_reset_mid_scan();
        test_leading_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_seg_scan.md
Name: conv_seg_scan

Overview:
- Downstream consumer of the 4-bit code converter (conv); takes each converted code {o1,o2,o3,o4} and drives a 4-digit common-anode 7-segment display.
- Keeps the last four valid codes in a shift buffer and scans them onto the display one digit at a time.
- Sits between the converter outputs and the board's seg/anode pins.
- Single clock domain.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Legal range 2..2^CNT_W-1.
- CNT_W, 16: width of the scan prescaler counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- code_i  input  4  converter output; code_i[3]=o1 (MSB) ... code_i[0]=o4.
- code_valid  input  1  single-cycle strobe; capture code_i this cycle.
- clear  input  1  synchronous buffer clear.
- seg_n  output  7  active-low segments; seg_n[6]=g ... seg_n[0]=a.
- an_n  output  4  active-low one-hot digit enable; an_n[0] is the rightmost digit.
- dig_cnt  output  3  number of loaded digits, 0..4, saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - buffer = 0, dig_cnt = 0.
  - prescaler = 0, digit select = 0.
  - an_n = 4'b1110, seg_n = 7'h7F (blank).
  - rst overrides every other input; asserting it mid-scan or mid-capture restarts everything from these values on the next edge.
- Capture:
  - On code_valid=1 (and clear=0): buf[3] <= buf[2], buf[2] <= buf[1], buf[1] <= buf[0], buf[0] <= code_i.
  - dig_cnt increments and saturates at 4. The oldest digit is discarded silently.
- Clear:
  - clear=1 zeroes the buffer and dig_cnt.
  - clear together with code_valid in the same cycle: clear wins and the code is dropped.
  - Scan position is unaffected.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. The cycle where it equals SCAN_DIV-1 is a tick.
  - On a tick, digit select advances 0→1→2→3→0.
- Output timing:
  - an_n and seg_n are registered and update on the edge after the tick, so each digit is shown for exactly SCAN_DIV cycles.
  - an_n is always exactly one zero. There is no all-off gap.
- Decode: seg_n = hex decode of buf[sel] when sel < dig_cnt, else 7'h7F (unloaded digits blank).
- Hex map:
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78
  - 8→0x00, 9→0x10, A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E
- Latency: a captured code is visible on the next registered update where sel selects its slot. This is at most 4·SCAN_DIV+1 cycles after code_valid.
- A capture landing in the same cycle as a tick is allowed. Decode uses the post-capture buffer on the following update.

Optional Feature:
- Macro: CONV_SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking. A loaded digit i (i≥1) is blanked when buf[i]==0 and every loaded digit above i is also 0. Digit 0 is never blanked.
- Not defined: every loaded zero shows as "0" (0x40).
- dig_cnt and scan timing are identical in both builds.

Decomposition:
- Package conv_pkg:
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex segment constant table.
  - Digit-count width constant (3).
- Sub-module seg7_dec: combinational 4-bit code → seg_n[6:0] using the conv_pkg table, instantiated once on the selected digit.

Test Plan (SCAN_DIV=4):
1. Reset and idle:
   - Stimulus: rst high 2 cycles, then idle.
   - Response: an_n cycles 1110→1101→1011→0111 every 4 cycles; seg_n stays 0x7F; dig_cnt=0.
2. Single capture:
   - Stimulus: code_i=4'h3 with code_valid 1 cycle.
   - Response: dig_cnt=1; seg_n=0x30 while an_n=1110; 0x7F on the other three digits.
3. Shift and saturate:
   - Stimulus: capture 1,2,A,F,8.
   - Response: dig_cnt=4; an_n=1110→0x00 (8), 1101→0x0E (F), 1011→0x08 (A), 0111→0x24 (2); the value 1 is gone.
4. Clear vs. valid collision:
   - Stimulus: after test 3, pulse clear and code_valid=1 (code 4'h5) in the same cycle.
   - Response: dig_cnt=0; all digits 0x7F; 5 is never displayed.
5. Reset mid-scan:
   - Stimulus: rst while an_n=1011 with dig_cnt=3.
   - Response: next edge an_n=1110, seg_n=0x7F, dig_cnt=0.
6. Leading zeros:
   - Stimulus: capture 0,0,7.
   - Response without CONV_SEG_LZ_BLANK_EN: digits 2,1,0 = 0x40, 0x40, 0x78.
   - Response with CONV_SEG_LZ_BLANK_EN: 0x7F, 0x7F, 0x78.
